wb_timer: RTL and testbench
===========================

WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s, wb_if.slave, WB_ADDR_WIDTH/WB_DATA_WIDTH: Wishbone slave port carrying adr, dat_w, dat_r, cyc, stb, we, sel, ack, err.
REQ-006 SHALL have port irq_o, output, 1 bit: level interrupt, intended for one bit of the CPU irq_i vector.

Function
REQ-007 Register map, decoded on adr[3:2]; adr bits above bit 3 are ignored within the window:
- 0x0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD, bits[15:8] PRESCALE; other bits read 0.
- 0x4 COUNT: read/write.
- 0x8 COMPARE: read/write.
- 0xC STATUS: bit0 MATCH; write 1 to clear.
REQ-008 Bus handshake:
- ack SHALL assert exactly one cycle after cyc&stb is sampled high with ack low.
- ack SHALL be a one-cycle pulse; a held request is acked every second cycle.
- err SHALL be 0 at all times.
REQ-009 Writes SHALL take effect on the ack cycle edge and honour sel per byte; bytes with sel=0 SHALL be unchanged.
REQ-010 Read data SHALL be registered and valid on dat_r while ack is high.
REQ-011 Tick generation:
- A tick occurs when EN=1 and the prescale counter equals PRESCALE; the prescale counter then wraps to 0.
- Otherwise the prescale counter increments while EN=1.
- The prescale counter clears to 0 while EN=0.
- PRESCALE=N gives one tick every N+1 cycles.
REQ-012 On a tick with COUNT==COMPARE:
- MATCH SHALL be set.
- COUNT SHALL load 0 if AUTO_RELOAD=1, else increment.
REQ-013 On a tick with COUNT!=COMPARE, COUNT SHALL increment modulo 2^32; 0xFFFFFFFF wraps to 0.
REQ-014 A bus write to COUNT in the same cycle as a tick SHALL win; the written value is loaded and no increment occurs that cycle.
REQ-015 A match SHALL be evaluated on the pre-write COUNT value; a simultaneous COUNT write does not suppress a MATCH set.
REQ-016 If a match occurs in the same cycle as a STATUS write-1-clear, set SHALL win and MATCH remains 1.
REQ-017 irq_o SHALL equal MATCH & IRQ_EN and be driven from flops with no combinational path from bus inputs.
REQ-018 Writing CTRL.EN=0 SHALL freeze COUNT and MATCH; neither is cleared.

Reset
REQ-019 While rst=1 at a clock edge, the following SHALL be cleared: CTRL, COUNT, prescale counter, MATCH, ack, dat_r, irq_o.
REQ-020 While rst=1, COMPARE SHALL load 0xFFFFFFFF.
REQ-021 A reset asserted during an outstanding bus cycle SHALL drop ack without completing the write.
REQ-022 After rst deasserts, the first ack SHALL occur no earlier than the second edge.

Configuration
REQ-023 Macro WB_TIMER_PRESCALER_EN defined: the PRESCALE field and prescale counter SHALL be implemented per REQ-011.
REQ-024 Macro WB_TIMER_PRESCALER_EN undefined: every cycle with EN=1 SHALL be a tick, CTRL[15:8] SHALL read 0, and writes to CTRL[15:8] SHALL be ignored.

Verification
REQ-025 Bus handshake: write COMPARE=0x10, read it back -> ack one cycle after stb; read returns 0x00000010; err stays 0.
REQ-026 Auto-reload: COMPARE=3, CTRL=0x7 (PRESCALE=0) -> COUNT sequence 0,1,2,3,0 and irq_o high one cycle after the 3->0 tick; write STATUS=1 -> irq_o low next cycle.
REQ-027 Prescaler (macro defined): PRESCALE=4, EN=1 -> COUNT increments every 5 cycles. Same stimulus with macro undefined -> COUNT increments every cycle and CTRL reads 0x00000001.
REQ-028 Wrap: COUNT=0xFFFFFFFE, COMPARE=5, AUTO_RELOAD=0, EN=1 -> COUNT reads 0xFFFFFFFF then 0x00000000; MATCH stays 0.
REQ-029 Collisions: COUNT write of 0x100 coinciding with a matching tick -> COUNT=0x100 and MATCH=1. STATUS clear coinciding with a match -> MATCH stays 1.
REQ-030 Reset mid-operation: assert rst during an outstanding COUNT write -> no ack; COUNT=0, COMPARE=0xFFFFFFFF, irq_o=0 afterwards.

Source files
------------

// File: rtl/wb_timer_if.sv
// wb_timer_if: classic Wishbone bus bundle (interface wb_if) with master and slave views.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic            ack;
    logic            err;

    modport master (output adr, dat_w, cyc, stb, we, sel, input dat_r, ack, err);
    modport slave  (input adr, dat_w, cyc, stb, we, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_timer.sv
// wb_timer: Wishbone 32-bit timer with compare match, auto-reload and level irq.
// Define WB_TIMER_PRESCALER_EN to build the 8-bit tick prescaler in CTRL[15:8].
module wb_timer #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  s,
    output logic irq_o
);
    logic                     en, irq_en, auto_reload, match, ack, rdy, tick, hit;
    logic                     req, wr, wr_ctrl, wr_count, wr_cmp, clr;
    logic [1:0]               idx;
    logic [7:0]               prescale;
    logic [31:0]              count, compare;
    logic [WB_DATA_WIDTH-1:0] rd_mux, dat_r;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? din[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign idx      = WB_ADDR_WIDTH > 3 ? s.adr[3:2] : 2'b00;
    // rdy holds off the first request until the second edge after reset
    assign req      = s.cyc && s.stb && !ack && rdy;
    assign wr       = req && s.we;
    assign wr_ctrl  = wr && idx == 2'd0;
    assign wr_count = wr && idx == 2'd1;
    assign wr_cmp   = wr && idx == 2'd2;
    assign clr      = wr && idx == 2'd3 && s.sel[0] && s.dat_w[0];
    assign hit      = tick && count == compare;

`ifdef WB_TIMER_PRESCALER_EN
    logic [7:0] psc;
    assign tick = en && psc == prescale;
    always_ff @(posedge clk) begin
        if (rst || !en || tick) psc <= '0;
        else psc <= psc + 8'd1;
        if (rst) prescale <= '0;
        else if (wr_ctrl && s.sel[1]) prescale <= s.dat_w[15:8];
    end
`else
    assign tick     = en;
    assign prescale = '0;
`endif

    always_comb
        rd_mux = idx == 2'd0 ? {16'd0, prescale, 5'd0, auto_reload, irq_en, en} :
                 idx == 2'd1 ? count :
                 idx == 2'd2 ? compare : {31'd0, match};

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy         <= 1'b0;
            ack         <= 1'b0;
            dat_r       <= '0;
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            count       <= '0;
            compare     <= '1;
            match       <= 1'b0;
        end else begin
            rdy <= 1'b1;
            ack <= req;
            if (req && !s.we) dat_r <= rd_mux;
            if (wr_ctrl && s.sel[0]) {auto_reload, irq_en, en} <= s.dat_w[2:0];
            // a bus write beats the tick; the match still uses the old count
            if (wr_count) count <= merge(count, s.dat_w, s.sel);
            else if (tick) count <= hit && auto_reload ? '0 : count + 32'd1;
            if (wr_cmp) compare <= merge(compare, s.dat_w, s.sel);
            if (hit) match <= 1'b1;
            else if (clr) match <= 1'b0;
        end
    end

    assign s.ack   = ack;
    assign s.dat_r = dat_r;
    assign s.err   = 1'b0;
    assign irq_o   = match & irq_en;
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed scoreboard bench for wb_timer; read expectations are queued
// when a read is issued and popped when its ack arrives.
module tb_wb_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irq_o;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    wb_if #(.AW(32), .DW(32)) b ();

    wb_timer #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s(b), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Called on a negedge; returns on the negedge where ack is seen.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] sel);
        int          n = 0;
        logic [31:0] e = 'x;
        if (b.ack) @(negedge clk);
        b.adr = a; b.we = w; b.dat_w = d; b.sel = sel; b.cyc = 1'b1; b.stb = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (b.ack !== 1'b1 && n < 8);
        check({tag, " ack_latency"}, n, 1);
        check({tag, " err"}, {31'd0, b.err}, 0);
        if (!w) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check({tag, " rdata"}, b.dat_r, e);
        end
        b.cyc = 1'b0; b.stb = 1'b0; b.we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sel = 4'hF);
        xfer(tag, a, 1'b1, d, sel);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        xfer(tag, a, 1'b0, 32'd0, 4'hF);
    endtask

    task automatic do_reset();
        b.cyc = 1'b0; b.stb = 1'b0; b.we = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] psc_count(input int n);
`ifdef WB_TIMER_PRESCALER_EN
        return 32'((n - 2) / 5);
`else
        return 32'(n - 2);
`endif
    endfunction

    initial begin
        int acks;
        b.adr = '0; b.dat_w = '0; b.sel = '0; b.cyc = 1'b0; b.stb = 1'b0; b.we = 1'b0;
        repeat (2) @(negedge clk);
        check("rst ack", {31'd0, b.ack}, 0);
        check("rst irq", {31'd0, irq_o}, 0);
        check("rst dat_r", b.dat_r, 0);
        check("rst err", {31'd0, b.err}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rd("rst ctrl", 32'h0, 32'h0);
        rd("rst count", 32'h4, 32'h0);
        rd("rst compare", 32'h8, 32'hFFFF_FFFF);
        rd("rst status", 32'hC, 32'h0);

        // handshake, byte enables and a held request
        wr("cmp wr", 32'h8, 32'h10);
        rd("cmp rd", 32'h8, 32'h10);
        wr("cmp sel", 32'h8, 32'hAABB_CCDD, 4'b0101);
        rd("cmp sel rd", 32'h1008, 32'h00BB_00DD);
        @(negedge clk);
        b.adr = 32'h8; b.we = 1'b0; b.cyc = 1'b1; b.stb = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            acks += int'(b.ack);
        end
        check("held acks", acks, 2);
        b.cyc = 1'b0; b.stb = 1'b0;
        @(negedge clk);

        // auto-reload: ticks from p2, 3->0 at p5, second match at p9, third at p13
        do_reset();
        wr("ar cmp", 32'h8, 32'd3);
        wr("ar ctrl", 32'h0, 32'h7);
        rd("ar count p3", 32'h4, 32'd1);
        check("ar irq before", {31'd0, irq_o}, 0);
        rd("ar count p5", 32'h4, 32'd3);
        check("ar irq after", {31'd0, irq_o}, 1);
        rd("ar count p7", 32'h4, 32'd1);
        wr("ar clr collide", 32'hC, 32'h1);
        check("ar set wins", {31'd0, irq_o}, 1);
        wr("ar clr", 32'hC, 32'h1);
        check("ar irq cleared", {31'd0, irq_o}, 0);
        rd("ar status", 32'hC, 32'h0);
        wr("ar stop", 32'h0, 32'h0);
        rd("ar frozen count", 32'h4, 32'd2);
        rd("ar frozen status", 32'hC, 32'h1);
        rd("ar frozen count2", 32'h4, 32'd2);

        // COUNT write colliding with a matching tick
        do_reset();
        wr("col cmp", 32'h8, 32'd4);
        wr("col ctrl", 32'h0, 32'h1);
        wr("col count3", 32'h4, 32'd3);
        wr("col count100", 32'h4, 32'h100);
        rd("col status", 32'hC, 32'h1);
        wr("col stop", 32'h0, 32'h0);
        rd("col count", 32'h4, 32'h104);

        // wrap through 0xFFFFFFFF without matching
        do_reset();
        wr("wrap cmp", 32'h8, 32'd5);
        wr("wrap count", 32'h4, 32'hFFFF_FFFE);
        wr("wrap ctrl", 32'h0, 32'h1);
        rd("wrap ff", 32'h4, 32'hFFFF_FFFF);
        wr("wrap stop", 32'h0, 32'h0);
        wr("wrap count2", 32'h4, 32'hFFFF_FFFD);
        wr("wrap ctrl2", 32'h0, 32'h1);
        rd("wrap fe", 32'h4, 32'hFFFF_FFFE);
        rd("wrap zero", 32'h4, 32'h0);
        rd("wrap status", 32'hC, 32'h0);

        // prescaler (or every-cycle tick when not built)
        do_reset();
        wr("psc ctrl", 32'h0, 32'h0401, 4'b0011);
`ifdef WB_TIMER_PRESCALER_EN
        rd("psc ctrl rd", 32'h0, 32'h0401);
`else
        rd("psc ctrl rd", 32'h0, 32'h0001);
`endif
        for (int k = 5; k <= 13; k += 2) rd("psc count", 32'h4, psc_count(k));

        // reset during an outstanding COUNT write
        do_reset();
        wr("rm cmp", 32'h8, 32'h0);
        wr("rm ctrl", 32'h0, 32'h3);
        @(negedge clk);
        check("rm irq set", {31'd0, irq_o}, 1);
        b.adr = 32'h4; b.we = 1'b1; b.dat_w = 32'h55; b.sel = 4'hF; b.cyc = 1'b1; b.stb = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rm no ack", {31'd0, b.ack}, 0);
        check("rm irq low", {31'd0, irq_o}, 0);
        @(negedge clk);
        b.cyc = 1'b0; b.stb = 1'b0; b.we = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rd("rm count", 32'h4, 32'h0);
        rd("rm compare", 32'h8, 32'hFFFF_FFFF);
        rd("rm ctrl", 32'h0, 32'h0);
        check("rm irq", {31'd0, irq_o}, 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
